// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch (I)
// and data-access (D) requesters of the multi-cycle CPU. One transaction runs at
// a time (IDLE -> ACCESS -> DONE). Simultaneous requests are granted round-robin,
// and an access that sees no inputReady within TIMEOUT_CYCLES is aborted with err.
module mem_port_arbiter #(
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value during the last ACCESS cycle allowed before the abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state;
    logic                 gnt_d;    // 1 = current transaction belongs to D
    logic                 last_d;   // 1 = most recent grant went to D
    logic [CNT_W-1:0]     cnt;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 pick_d;

    // D wins when it is the only requester, or on a tie when I was served last.
    assign pick_d = d_req & (~i_req | ~last_d);

    // The bus is only driven while a write strobe is active; otherwise released.
    assign data = writeM ? wdata_q : {WORD_SIZE{1'bz}};

    // Latch the write data of a D grant so it is stable for the whole access.
    always_ff @(posedge clk) begin
        if (state == IDLE && pick_d) begin
            wdata_q <= d_wdata;
        end
    end

    // Transaction sequencer: grant, strobe until ready/timeout, one-cycle ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            readM   <= 1'b0;
            writeM  <= 1'b0;
            address <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            err     <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            cnt     <= '0;
            last_d  <= 1'b1;
            gnt_d   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        gnt_d   <= pick_d;
                        last_d  <= pick_d;
                        address <= pick_d ? d_addr : i_addr;
                        readM   <= ~(pick_d & d_we);
                        writeM  <= pick_d & d_we;
                        cnt     <= '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (inputReady) begin
                        if (readM) begin
                            if (gnt_d) d_rdata <= data;
                            else       i_rdata <= data;
                        end
                        readM  <= 1'b0;
                        writeM <= 1'b0;
                        i_ack  <= ~gnt_d;
                        d_ack  <= gnt_d;
                        state  <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Abort: report all-ones data and flag the error.
                        if (gnt_d) d_rdata <= '1;
                        else       i_rdata <= '1;
                        err    <= 1'b1;
                        readM  <= 1'b0;
                        writeM <= 1'b0;
                        i_ack  <= ~gnt_d;
                        d_ack  <= gnt_d;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a memory model with programmable latency and a
// transaction-level reference (round-robin rule, expected timing, reference memory).
module tb_mem_port_arbiter;

    localparam int W  = 16;
    localparam int TO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n = 1'b0;
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [W-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [W-1:0] i_rdata, d_rdata, address;
    logic         i_ack, d_ack, err, readM, writeM;
    logic         inputReady = 1'b0;
    wire  [W-1:0] data_bus;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .readM(readM), .writeM(writeM), .address(address),
        .data(data_bus), .inputReady(inputReady)
    );

    // Initial memory contents (address 0x0010 holds 0x1234).
    function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
        if (a == 16'h0010) return 16'h1234;
        return (a * 16'h0101) ^ 16'hA5C3;
    endfunction

    // ---------------- memory device model ----------------
    logic         mem_clr = 1'b1;
    logic         dev_written [256];
    logic [W-1:0] dev_val [256];
    logic [W-1:0] dev_rd;
    int           mem_lat = 1;   // 1..N: ready on Nth access cycle; 0: never
    int           acc_cnt = 0;

    assign dev_rd   = dev_written[address[7:0]] ? dev_val[address[7:0]] : init_val(address);
    assign data_bus = (readM && inputReady) ? dev_rd : {W{1'bz}};

    always @(negedge clk) begin
        if (readM || writeM) begin
            acc_cnt    <= acc_cnt + 1;
            inputReady <= (acc_cnt + 1 == mem_lat);
        end else begin
            acc_cnt    <= 0;
            inputReady <= 1'($urandom_range(0, 1));  // noise, must be ignored
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) dev_written[i] <= 1'b0;
        end else if (writeM && inputReady) begin
            dev_written[address[7:0]] <= 1'b1;
            dev_val[address[7:0]]     <= data_bus;
        end
    end

    // ---------------- reference model state ----------------
    logic [W-1:0] ref_mem [256];
    bit           i_pend = 0, d_pend = 0, d_w = 0;
    logic [W-1:0] i_a = '0, d_a = '0, d_wd = '0;
    bit           last_d = 1;
    logic [W-1:0] exp_i_rd = '0, exp_d_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reqs();
        i_req   = i_pend;
        i_addr  = i_a;
        d_req   = d_pend;
        d_we    = d_w;
        d_addr  = d_a;
        d_wdata = d_wd;
    endtask

    // One full transaction, starting at a negedge while the DUT is idle.
    task automatic run_txn(input int lat);
        bit           win_d, tmo, we;
        logic [W-1:0] a, wd, exp_rd;
        int           kdone;
        apply_reqs();
        win_d  = (i_pend && d_pend) ? !last_d : d_pend;
        last_d = win_d;
        we     = win_d && d_w;
        a      = win_d ? d_a : i_a;
        wd     = d_wd;
        tmo    = !(lat >= 1 && lat <= TO);
        kdone  = tmo ? TO : lat;
        mem_lat = lat;
        for (int k = 0; k < kdone; k++) begin
            step();
            chk("readM_busy", readM, !we);
            chk("writeM_busy", writeM, we);
            chk("address_busy", address, a);
            chk("acks_busy", {i_ack, d_ack}, 0);
            chk("err_busy", err, 0);
            if (we) chk("bus_write", data_bus, wd);
        end
        step();
        if (tmo)     exp_rd = 16'hFFFF;
        else if (we) exp_rd = exp_d_rd;
        else         exp_rd = ref_mem[a[7:0]];
        if (!tmo && we) ref_mem[a[7:0]] = wd;
        if (win_d) exp_d_rd = exp_rd;
        else       exp_i_rd = exp_rd;
        chk("i_ack_done", i_ack, !win_d);
        chk("d_ack_done", d_ack, win_d);
        chk("err_done", err, tmo);
        chk("strobes_done", {readM, writeM}, 0);
        if (win_d) chk("d_rdata", d_rdata, exp_d_rd);
        else       chk("i_rdata", i_rdata, exp_i_rd);
        if (win_d) d_pend = 0;
        else       i_pend = 0;
        step();
        chk("acks_idle", {i_ack, d_ack}, 0);
        chk("err_idle", err, 0);
        chk("strobes_idle", {readM, writeM}, 0);
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 0;
        if (r == 1) return 15;
        if (r == 2) return 16;
        return $urandom_range(1, 4);
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(16'(i));
        @(negedge clk);
        repeat (3) step();
        chk("rst_readM", readM, 0);
        chk("rst_writeM", writeM, 0);
        chk("rst_address", address, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_err", err, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset_n = 1'b1;
        mem_clr = 1'b0;

        // Fetch from 0x0010
        i_pend = 1; i_a = 16'h0010;
        run_txn(1);

        // D write then read back
        d_pend = 1; d_w = 1; d_a = 16'h0020; d_wd = 16'hBEEF;
        run_txn(2);
        d_pend = 1; d_w = 0; d_a = 16'h0020;
        run_txn(1);

        // Both held: I, D, I, D
        i_pend = 1; i_a = 16'h0011;
        d_pend = 1; d_w = 0; d_a = 16'h0012;
        run_txn(1);
        i_pend = 1; i_a = 16'h0013;
        run_txn(1);
        d_pend = 1; d_w = 1; d_a = 16'h0014; d_wd = 16'h5AA5;
        run_txn(1);
        run_txn(1);
        i_pend = 0;

        // Timeouts and the ready-on-last-cycle boundary
        i_pend = 1; i_a = 16'h0030;
        run_txn(0);
        d_pend = 1; d_w = 0; d_a = 16'h0010;
        run_txn(1);
        i_pend = 1; i_a = 16'h0031;
        run_txn(15);
        i_pend = 1; i_a = 16'h0032;
        run_txn(16);
        d_pend = 1; d_w = 1; d_a = 16'h0033; d_wd = 16'h7777;
        run_txn(0);
        d_pend = 1; d_w = 0; d_a = 16'h0033;
        run_txn(2);

        // Reset during ACCESS discards the transaction
        i_pend = 1; i_a = 16'h0034;
        apply_reqs();
        mem_lat = 0;
        step();
        chk("pre_rst_readM", readM, 1);
        step();
        reset_n = 1'b0;
        step();
        chk("midrst_strobes", {readM, writeM}, 0);
        chk("midrst_acks", {i_ack, d_ack}, 0);
        chk("midrst_err", err, 0);
        chk("midrst_i_rdata", i_rdata, 0);
        d_pend = 1; d_w = 0; d_a = 16'h0035;
        apply_reqs();
        step();
        chk("midrst_hold_strobes", {readM, writeM}, 0);
        chk("midrst_hold_acks", {i_ack, d_ack}, 0);
        reset_n = 1'b1;
        last_d = 1; exp_i_rd = '0; exp_d_rd = '0;
        run_txn(2);
        run_txn(1);

        // Sequential fetch with i_req held continuously
        for (int n = 0; n < 6; n++) begin
            i_pend = 1; i_a = 16'(16'h0040 + n);
            run_txn(1);
        end

        // Randomized traffic
        repeat (150) begin
            if (!i_pend && $urandom_range(0, 99) < 60) begin
                i_pend = 1; i_a = 16'($urandom_range(0, 255));
            end
            if (!d_pend && $urandom_range(0, 99) < 60) begin
                d_pend = 1; d_w = 1'($urandom_range(0, 1));
                d_a = 16'($urandom_range(0, 255)); d_wd = 16'($urandom);
            end
            if (i_pend || d_pend) begin
                run_txn(pick_lat());
            end else begin
                apply_reqs();
                step();
                chk("idle_strobes", {readM, writeM}, 0);
                chk("idle_acks", {i_ack, d_ack}, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
